temp_sensor_reader: RTL

- Producer side of the temperature averaging path: periodically reads one 8-bit signed sample from an external serial temperature sensor over a 3-wire SPI-style link (mode 0, read-only).
- Checks the sample's even-parity bit.
- Presents the sample as `temperature_o` with a one-cycle `valid_o` strobe, which drives the `temperature` input of the moving-average block.

---
 rtl/temp_sensor_pkg.sv | 28 ++
 rtl/temp_sensor_reader_sclk_gen.sv | 48 ++++
 rtl/temp_sensor_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/temp_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module : temp_sensor_pkg
// Brief  : Shared types and constants for the temperature sensor reader.
// Rev    : 1.0
// ============================================================================
package temp_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_PUBLISH = 3'd4
    } state_e;

    typedef logic signed [7:0] temp_t;

    localparam int FRAME_BITS  = 9;
    localparam int HOLD_HALVES = 1;

    // Frame layout is {data[7:0], parity}; even parity means the data XOR equals the parity bit.
    function automatic logic parity_ok(input logic [FRAME_BITS-1:0] frame);
        return (^frame[FRAME_BITS-1:1]) == frame[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/temp_sensor_reader_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module : sclk_gen
// Brief  : Half-period divider producing the serial clock and edge strobes.
// Rev    : 1.0
// ============================================================================
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                 c_cnt_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sclk;
    logic               w_half_done;

    assign w_half_done = en_i && (r_cnt == c_cnt_max);

    // Disabled means parked low with a fresh count, so each frame starts aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!en_i) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_half_done) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign sclk_o = r_sclk;
    assign rise_o = w_half_done && !r_sclk;
    assign fall_o = w_half_done &&  r_sclk;

endmodule
`default_nettype wire

// File: rtl/temp_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module : temp_sensor_reader
// Brief  : Periodic read-only serial reader for a parity-protected 8-bit signed sample.
// Rev    : 1.0
// ============================================================================
module temp_sensor_reader
    import temp_sensor_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  en_i,
    input  logic  sdi_i,
    output logic  cs_no,
    output logic  sclk_o,
    output temp_t temperature_o,
    output logic  valid_o,
    output logic  err_o,
    output logic  busy_o
);

    localparam int                  c_per_w       = $clog2(SAMPLE_PERIOD);
    localparam logic [c_per_w-1:0]  c_per_reload  = c_per_w'(SAMPLE_PERIOD - 1);
    localparam int                  c_hold_cycles = HOLD_HALVES * CLK_DIV;
    localparam int                  c_hold_w      = $clog2(c_hold_cycles + 1);
    localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(c_hold_cycles - 1);
    localparam int                  c_bit_w       = $clog2(FRAME_BITS + 1);
    localparam logic [c_bit_w-1:0]  c_bit_last    = c_bit_w'(FRAME_BITS - 1);

    state_e                r_state;
    state_e                w_next;
    logic [c_per_w-1:0]    r_period;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_good;
    temp_t                 r_temp;

    logic w_rise;
    logic w_fall;
    logic w_frame_start;
    logic w_shift_done;
    logic w_hold_done;
    logic w_publish_load;

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (r_state == ST_SHIFT),
        .sclk_o (sclk_o),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign w_shift_done   = w_fall && (r_bit_cnt == c_bit_last);
    assign w_hold_done    = (r_hold_cnt == c_hold_last);
    assign w_frame_start  = (w_next == ST_SHIFT) && (r_state != ST_SHIFT);
    assign w_publish_load = (r_state == ST_HOLD) && w_hold_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (en_i) w_next = ST_SHIFT;
            ST_WAIT: begin
                if (!en_i)                 w_next = ST_IDLE;
                else if (r_period == '0)   w_next = ST_SHIFT;
            end
            ST_SHIFT:   if (w_shift_done) w_next = ST_HOLD;
            ST_HOLD:    if (w_hold_done)  w_next = ST_PUBLISH;
            ST_PUBLISH: w_next = en_i ? ST_WAIT : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_no   = 1'b1;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        err_o   = 1'b0;
        case (r_state)
            ST_SHIFT, ST_HOLD: begin
                cs_no  = 1'b0;
                busy_o = 1'b1;
            end
            ST_PUBLISH: begin
                busy_o  = 1'b1;
                valid_o = r_good;
                err_o   = !r_good;
            end
            default: ;
        endcase
    end

    // Period counter runs through the whole frame so frame starts stay SAMPLE_PERIOD apart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_period <= '0;
        end else if (w_frame_start) begin
            r_period <= c_per_reload;
        end else if ((r_state != ST_IDLE) && (r_period != '0)) begin
            r_period <= r_period - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (r_state != ST_SHIFT) r_bit_cnt <= '0;
            else if (w_fall)         r_bit_cnt <= r_bit_cnt + 1'b1;

            if (r_state != ST_HOLD)  r_hold_cnt <= '0;
            else                     r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift <= '0;
        end else if (w_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], sdi_i};
        end
    end

    // Verdict and sample land on the edge entering PUBLISH so they line up with the strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_good <= 1'b0;
            r_temp <= '0;
        end else if (w_publish_load) begin
            r_good <= parity_ok(r_shift);
            if (parity_ok(r_shift)) begin
                r_temp <= temp_t'(r_shift[FRAME_BITS-1:1]);
            end
        end
    end

    assign temperature_o = r_temp;

endmodule
`default_nettype wire
